pc_context_scheduler: RTL and testbench
=======================================

# pc_context_scheduler

Issue-side controller for the five-entry PC repository. It tracks which hardware contexts are active, chooses one eligible context per fetch slot by round-robin, and reads that context's PC through the repository read port. It writes start PCs and returned next-PCs back through the repository write port. It sits between the repository and the fetch stage and is the only agent driving the repository's select, enable and clear inputs.

## Interface
- NUM_CTX, 5, number of contexts; must equal repository depth
- CTX_W, 3, context index width
- XLEN, 32, PC width
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- start_valid / start_ready  in / out  1 / 1  context start handshake
- start_ctx, start_pc  in  CTX_W, XLEN  context to start and its initial PC
- halt_valid, halt_ctx  in  1, CTX_W  deactivate a context
- stall  in  NUM_CTX  per-context stall level (e.g. I-miss)
- flush  in  1  global kill
- rep_en, rep_clear  out  1, 1  repository write enable and clear
- rep_sel_read, rep_sel_write  out  CTX_W  repository read and write selects
- rep_d  out  XLEN  repository write data
- rep_q  in  XLEN  repository read data (combinational from rep_sel_read)
- fetch_valid / fetch_ready  out / in  1  fetch handshake
- fetch_ctx, fetch_pc  out  CTX_W, XLEN  granted context and its PC
- next_valid, next_ctx, next_pc  in  1, CTX_W, XLEN  next-PC writeback from fetch

## Operation
- State registers: active[NUM_CTX], inflight[NUM_CTX], rr_ptr, lock, locked_ctx.
- FSM: S_INIT, S_IDLE, S_RUN.
  - S_INIT: rep_clear=1 for one cycle, then S_IDLE. Entered on reset release and on flush from any state.
  - S_IDLE → S_RUN when any active bit is set.
  - S_RUN → S_IDLE when active and inflight are both all-zero.
- Eligibility: eligible[c] = active[c] & ~inflight[c] & ~stall[c].
- Grant: first eligible context at or after rr_ptr, wrapping modulo NUM_CTX.
  - If lock=1, the grant is locked_ctx and its stall bit is ignored.
- Fetch outputs:
  - rep_sel_read = grant.
  - fetch_pc = rep_q.
  - fetch_ctx = grant.
  - fetch_valid = S_RUN & (lock | any eligible).
- Handshake (fetch_valid & fetch_ready):
  - Sets inflight[grant].
  - rr_ptr becomes (grant+1) mod NUM_CTX.
  - Clears lock.
- fetch_valid & ~fetch_ready sets lock and locked_ctx=grant.
  - fetch_ctx and fetch_pc stay stable until the handshake completes.
  - Only halt of that context or flush withdraws a locked request.
- Write port arbitration; next has priority:
  - next_valid with next_ctx < NUM_CTX and active[next_ctx]: rep_en=1, rep_sel_write=next_ctx, rep_d=next_pc, and inflight[next_ctx] is cleared.
  - next_valid for an inactive or out-of-range context: no write, but inflight is still cleared if in range.
  - start_ready = ~S_INIT & ~next_valid & ~inflight[start_ctx].
  - Start accept: rep_en=1, rep_sel_write=start_ctx, rep_d=start_pc, active[start_ctx] set. Out-of-range start_ctx is consumed with no effect.
- Halt: clears active[halt_ctx] and inflight[halt_ctx], and drops the lock if locked_ctx=halt_ctx.
  - Halt and start on the same context in the same cycle: the PC is written, and halt wins on active.
- Flush: clears active, inflight and lock, and forces S_INIT.
  - next_valid and start are ignored in the flush cycle.
  - start_ready=0 in the flush cycle.

## Timing
- While reset is low, all outputs are 0 and state is S_INIT.
- rep_clear=1 in the first cycle after reset release.
- Read path is combinational: rep_sel_read to rep_q to fetch_pc in the same cycle.
- A write in cycle t is visible on rep_q in t+1. A start accepted at t gives fetch_valid at t+1 with fetch_pc=start_pc, provided the context is unstalled and wins the grant.
- With one context: fetch at t; next_valid at t+k; refetch earliest at t+k+1.
- Full throughput is one fetch per cycle when at least two contexts are eligible and the round-trip is covered.
- All-stalled or all-inflight: fetch_valid=0 and the FSM stays in S_RUN.

## Structure
- Package pc_sched_pkg holds: NUM_CTX, CTX_W, XLEN, and the state enum (S_INIT, S_IDLE, S_RUN).
- One sub-module, rr_arbiter: rotating-priority pick over an NUM_CTX-bit request vector with a pointer input. It is purely combinational.
- The top level holds the FSM, the state registers and the write mux.

## Test plan
- Reset release: rep_clear pulses for one cycle, fetch_valid=0 and start_ready=1 from cycle 2.
- Start ctx2 with PC 0x1000, fetch_ready=1: fetch_valid next cycle with fetch_ctx=2 and fetch_pc=0x1000. Return next_pc 0x1004; the following fetch shows 0x1004.
- Start ctx0, ctx1 and ctx4 with fetch_ready=1 and next_pc returned after 1 cycle: grants cycle 0,1,4,0,1,4.
- Hold fetch_ready=0 on ctx1 while raising stall[1] and starting ctx3: fetch_ctx stays 1 and fetch_pc stays stable. ctx1 completes first after fetch_ready rises.
- next_valid and start_valid in the same cycle: next is written and start_ready=0. Start is accepted the next cycle. Also: halt of ctx3 while it is inflight, then next_valid for ctx3, gives no write.
- Flush mid-run with two contexts inflight: rep_clear next cycle, active=0, fetch_valid=0, and state S_IDLE after S_INIT.

Source files
------------

// File: rtl/pc_context_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// pc_sched_pkg
// Shared sizing, FSM state type and context-index helpers for the PC context
// scheduler and its round-robin arbiter.
//   NUM_CTX : number of hardware contexts (equals PC repository depth)
//   CTX_W   : context index width
//   XLEN    : PC width
// ---------------------------------------------------------------------------
package pc_sched_pkg;

  localparam int unsigned NUM_CTX = 5;
  localparam int unsigned CTX_W   = 3;
  localparam int unsigned XLEN    = 32;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_RUN
  } sched_state_e;

  typedef logic [CTX_W-1:0] ctx_t;

  // One-hot mask for a context index; out-of-range indices give an empty
  // mask, so callers never index a per-context vector out of bounds.
  function automatic logic [NUM_CTX-1:0] ctx_mask(input ctx_t c);
    logic [NUM_CTX-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_CTX; i++) begin
      if (32'(c) == i) m[i] = 1'b1;
    end
    return m;
  endfunction

  // (c + 1) mod NUM_CTX
  function automatic ctx_t ctx_inc(input ctx_t c);
    ctx_t r;
    if (32'(c) >= NUM_CTX - 1) r = '0;
    else                       r = c + CTX_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/pc_context_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational rotating-priority pick: returns the first asserted
// request at or after ptr_i, wrapping modulo N.
//   req_i   : N-bit request vector
//   ptr_i   : highest-priority index for this pick
//   gnt_o   : index of the chosen request (0 when none)
//   valid_o : at least one request asserted
// ---------------------------------------------------------------------------
module rr_arbiter
  import pc_sched_pkg::*;
#(
  parameter int unsigned N = NUM_CTX,
  parameter int unsigned W = CTX_W
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] gnt_o,
  output logic         valid_o
);

  int unsigned idx;
  logic        found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr_i) + i) % N;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        gnt_o = W'(idx);
      end
    end
  end

  assign valid_o = found;

endmodule

// File: rtl/pc_context_scheduler.sv
// ---------------------------------------------------------------------------
// pc_context_scheduler
// Issue-side controller for the PC repository. Tracks active contexts, picks
// one eligible context per fetch slot round-robin, reads its PC through the
// repository read port, and writes start PCs / returned next-PCs through the
// repository write port.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   start_valid_i/start_ready_o   context start handshake
//   start_ctx_i, start_pc_i       context to start and its initial PC
//   halt_valid_i, halt_ctx_i      deactivate a context
//   stall_i                       per-context stall level
//   flush_i                       global kill
//   rep_en_o, rep_clear_o         repository write enable / clear
//   rep_sel_read_o, rep_sel_write_o, rep_d_o, rep_q_i  repository ports
//   fetch_valid_o/fetch_ready_i   fetch handshake
//   fetch_ctx_o, fetch_pc_o       granted context and its PC
//   next_valid_i, next_ctx_i, next_pc_i  next-PC writeback from fetch
// ---------------------------------------------------------------------------
module pc_context_scheduler
  import pc_sched_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_valid_i,
  output logic               start_ready_o,
  input  logic [CTX_W-1:0]   start_ctx_i,
  input  logic [XLEN-1:0]    start_pc_i,
  input  logic               halt_valid_i,
  input  logic [CTX_W-1:0]   halt_ctx_i,
  input  logic [NUM_CTX-1:0] stall_i,
  input  logic               flush_i,
  output logic               rep_en_o,
  output logic               rep_clear_o,
  output logic [CTX_W-1:0]   rep_sel_read_o,
  output logic [CTX_W-1:0]   rep_sel_write_o,
  output logic [XLEN-1:0]    rep_d_o,
  input  logic [XLEN-1:0]    rep_q_i,
  output logic               fetch_valid_o,
  input  logic               fetch_ready_i,
  output logic [CTX_W-1:0]   fetch_ctx_o,
  output logic [XLEN-1:0]    fetch_pc_o,
  input  logic               next_valid_i,
  input  logic [CTX_W-1:0]   next_ctx_i,
  input  logic [XLEN-1:0]    next_pc_i
);

  sched_state_e       state_q, state_d;
  logic [NUM_CTX-1:0] active_q, active_d;
  logic [NUM_CTX-1:0] inflight_q, inflight_d;
  logic [CTX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               lock_q, lock_d;
  logic [CTX_W-1:0]   locked_ctx_q, locked_ctx_d;

  logic [NUM_CTX-1:0] eligible;
  logic [CTX_W-1:0]   arb_gnt;
  logic               arb_valid;
  logic [CTX_W-1:0]   grant;
  logic               handshake;

  logic [NUM_CTX-1:0] next_mask, start_mask, halt_mask, grant_mask;
  logic               next_wr, start_acc, start_wr;

  // -------------------------------------------------------------------------
  // Grant selection
  // -------------------------------------------------------------------------
  assign eligible = active_q & ~inflight_q & ~stall_i;

  rr_arbiter #(
    .N (NUM_CTX),
    .W (CTX_W)
  ) u_rr_arbiter (
    .req_i   (eligible),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  // A refused request stays pinned to its context (stall ignored) so the
  // fetch stage sees stable ctx/pc until it accepts.
  assign grant      = lock_q ? locked_ctx_q : arb_gnt;
  assign grant_mask = ctx_mask(grant);
  assign next_mask  = ctx_mask(next_ctx_i);
  assign start_mask = ctx_mask(start_ctx_i);
  assign halt_mask  = ctx_mask(halt_ctx_i);

  // A request raised in the flush cycle is killed before it can be taken.
  assign fetch_valid_o  = (state_q == S_RUN) & (lock_q | arb_valid) & ~flush_i;
  assign handshake      = fetch_valid_o & fetch_ready_i;
  assign fetch_ctx_o    = grant;
  assign rep_sel_read_o = grant;
  assign fetch_pc_o     = fetch_valid_o ? rep_q_i : '0;

  // -------------------------------------------------------------------------
  // Write port: next-PC writeback has priority over context start
  // -------------------------------------------------------------------------
  assign next_wr       = next_valid_i & ~flush_i & (|(active_q & next_mask));
  assign start_ready_o = (state_q != S_INIT) & ~next_valid_i & ~flush_i
                       & ~(|(inflight_q & start_mask));
  assign start_acc     = start_valid_i & start_ready_o;
  assign start_wr      = start_acc & (|start_mask);

  always_comb begin
    rep_en_o        = 1'b0;
    rep_sel_write_o = '0;
    rep_d_o         = '0;
    if (next_wr) begin
      rep_en_o        = 1'b1;
      rep_sel_write_o = next_ctx_i;
      rep_d_o         = next_pc_i;
    end else if (start_wr) begin
      rep_en_o        = 1'b1;
      rep_sel_write_o = start_ctx_i;
      rep_d_o         = start_pc_i;
    end
  end

  // Held low while in reset so every output is quiet until release.
  assign rep_clear_o = (state_q == S_INIT) & rst_ni;

  // -------------------------------------------------------------------------
  // Context state update. Later statements override earlier ones:
  // writeback/start, then fetch, then halt, then flush.
  // -------------------------------------------------------------------------
  always_comb begin
    active_d     = active_q;
    inflight_d   = inflight_q;
    rr_ptr_d     = rr_ptr_q;
    lock_d       = lock_q;
    locked_ctx_d = locked_ctx_q;

    // Returned next-PC ends the round trip even for an inactive context.
    if (next_valid_i && !flush_i) inflight_d = inflight_d & ~next_mask;
    if (start_acc)                active_d   = active_d | start_mask;

    if (handshake) begin
      inflight_d = inflight_d | grant_mask;
      rr_ptr_d   = ctx_inc(grant);
      lock_d     = 1'b0;
    end else if (fetch_valid_o) begin
      lock_d       = 1'b1;
      locked_ctx_d = grant;
    end

    if (halt_valid_i) begin
      active_d   = active_d & ~halt_mask;
      inflight_d = inflight_d & ~halt_mask;
      if (lock_d && (locked_ctx_d == halt_ctx_i)) lock_d = 1'b0;
    end

    if (flush_i) begin
      active_d   = '0;
      inflight_d = '0;
      lock_d     = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // FSM. Transitions look at next-cycle context state so a start accepted in
  // S_IDLE can present its fetch in the very next cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:  state_d = S_IDLE;
      S_IDLE:  if (|active_d) state_d = S_RUN;
      S_RUN:   if (active_d == '0 && inflight_d == '0) state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
    if (flush_i) state_d = S_INIT;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_INIT;
      active_q     <= '0;
      inflight_q   <= '0;
      rr_ptr_q     <= '0;
      lock_q       <= 1'b0;
      locked_ctx_q <= '0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      inflight_q   <= inflight_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_q       <= lock_d;
      locked_ctx_q <= locked_ctx_d;
    end
  end

endmodule

// File: tb/tb_pc_context_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pc_context_scheduler
// Directed bench for pc_context_scheduler with a behavioural 5-entry PC
// repository (combinational read, clocked write, synchronous clear).
// Inputs change on the falling edge; outputs are checked 1 ns later.
// ---------------------------------------------------------------------------
module tb_pc_context_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid, start_ready;
  logic [2:0]  start_ctx;
  logic [31:0] start_pc;
  logic        halt_valid;
  logic [2:0]  halt_ctx;
  logic [4:0]  stall;
  logic        flush;
  logic        rep_en, rep_clear;
  logic [2:0]  rep_sel_read, rep_sel_write;
  logic [31:0] rep_d, rep_q;
  logic        fetch_valid, fetch_ready;
  logic [2:0]  fetch_ctx;
  logic [31:0] fetch_pc;
  logic        next_valid;
  logic [2:0]  next_ctx;
  logic [31:0] next_pc;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [5];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rep_clear) begin
      for (int i = 0; i < 5; i++) mem[i] <= '0;
    end else if (rep_en && rep_sel_write < 3'd5) begin
      mem[rep_sel_write] <= rep_d;
    end
  end

  assign rep_q = (rep_sel_read < 3'd5) ? mem[rep_sel_read] : '0;

  pc_context_scheduler dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_valid_i   (start_valid),
    .start_ready_o   (start_ready),
    .start_ctx_i     (start_ctx),
    .start_pc_i      (start_pc),
    .halt_valid_i    (halt_valid),
    .halt_ctx_i      (halt_ctx),
    .stall_i         (stall),
    .flush_i         (flush),
    .rep_en_o        (rep_en),
    .rep_clear_o     (rep_clear),
    .rep_sel_read_o  (rep_sel_read),
    .rep_sel_write_o (rep_sel_write),
    .rep_d_o         (rep_d),
    .rep_q_i         (rep_q),
    .fetch_valid_o   (fetch_valid),
    .fetch_ready_i   (fetch_ready),
    .fetch_ctx_o     (fetch_ctx),
    .fetch_pc_o      (fetch_pc),
    .next_valid_i    (next_valid),
    .next_ctx_i      (next_ctx),
    .next_pc_i       (next_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fetch(input string tag, input logic [2:0] ctx, input logic [31:0] pc);
    chk({tag, ".valid"}, 32'(fetch_valid), 32'd1);
    chk({tag, ".ctx"},   32'(fetch_ctx),   32'(ctx));
    chk({tag, ".pc"},    fetch_pc,         pc);
  endtask

  task automatic chk_wr(input string tag, input logic [2:0] sel, input logic [31:0] d);
    chk({tag, ".en"},  32'(rep_en),        32'd1);
    chk({tag, ".sel"}, 32'(rep_sel_write), 32'(sel));
    chk({tag, ".d"},   rep_d,              d);
  endtask

  int          exp_ctx [6] = '{0, 1, 4, 0, 1, 4};
  logic [31:0] exp_pc  [6] = '{32'h2000, 32'h3000, 32'h4000, 32'h2004, 32'h3004, 32'h4004};

  initial begin
    start_valid = 0; start_ctx = 0; start_pc = 0;
    halt_valid = 0; halt_ctx = 0; stall = '0; flush = 0;
    fetch_ready = 0; next_valid = 0; next_ctx = 0; next_pc = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    // ---- reset: outputs quiet
    chk("rst.clear",  32'(rep_clear),   32'd0);
    chk("rst.fvalid", 32'(fetch_valid), 32'd0);
    chk("rst.sready", 32'(start_ready), 32'd0);
    chk("rst.en",     32'(rep_en),      32'd0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("init.clear",  32'(rep_clear),   32'd1);
    chk("init.sready", 32'(start_ready), 32'd0);
    chk("init.fvalid", 32'(fetch_valid), 32'd0);
    @(negedge clk); #1;
    chk("idle.clear",  32'(rep_clear),   32'd0);
    chk("idle.sready", 32'(start_ready), 32'd1);
    chk("idle.fvalid", 32'(fetch_valid), 32'd0);

    // ---- single context start / fetch / writeback / refetch
    start_valid = 1; start_ctx = 3'd2; start_pc = 32'h1000; fetch_ready = 1; #1;
    chk_wr("s2.wr", 3'd2, 32'h1000);
    @(negedge clk); start_valid = 0; #1;
    chk_fetch("s2.f0", 3'd2, 32'h1000);
    @(negedge clk); next_valid = 1; next_ctx = 3'd2; next_pc = 32'h1004; #1;
    chk("s2.inflight.fvalid", 32'(fetch_valid), 32'd0);
    chk("s2.next.sready",     32'(start_ready), 32'd0);
    chk_wr("s2.next", 3'd2, 32'h1004);
    @(negedge clk); next_valid = 0; #1;
    chk_fetch("s2.f1", 3'd2, 32'h1004);
    @(negedge clk); fetch_ready = 0; halt_valid = 1; halt_ctx = 3'd2; #1;
    @(negedge clk); halt_valid = 0; #1;
    chk("s2.halted.fvalid", 32'(fetch_valid), 32'd0);

    // ---- three contexts, round robin with 1-cycle return
    start_valid = 1; start_ctx = 3'd0; start_pc = 32'h2000; #1;
    chk("rr.s0.sready", 32'(start_ready), 32'd1);
    @(negedge clk); start_ctx = 3'd1; start_pc = 32'h3000; #1;
    chk_fetch("rr.lock0", 3'd0, 32'h2000);
    @(negedge clk); start_ctx = 3'd4; start_pc = 32'h4000; #1;
    @(negedge clk); start_valid = 0; fetch_ready = 1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        next_valid = 1; next_ctx = 3'(exp_ctx[i-1]); next_pc = exp_pc[i-1] + 32'd4;
      end
      #1;
      chk_fetch($sformatf("rr.g%0d", i), 3'(exp_ctx[i]), exp_pc[i]);
      @(negedge clk);
    end
    next_valid = 0; #1;
    chk_fetch("rr.g6", 3'd0, 32'h2008);

    // ---- flush with ctx0 and ctx4 inflight
    @(negedge clk); flush = 1; fetch_ready = 0;
    start_valid = 1; start_ctx = 3'd3; start_pc = 32'h9999;
    next_valid = 1; next_ctx = 3'd4; next_pc = 32'h4444; #1;
    chk("fl.fvalid", 32'(fetch_valid), 32'd0);
    chk("fl.sready", 32'(start_ready), 32'd0);
    chk("fl.en",     32'(rep_en),      32'd0);
    @(negedge clk); flush = 0; start_valid = 0; next_valid = 0; #1;
    chk("fl.clear",       32'(rep_clear),   32'd1);
    chk("fl.init.fvalid", 32'(fetch_valid), 32'd0);
    chk("fl.init.sready", 32'(start_ready), 32'd0);
    @(negedge clk); #1;
    chk("fl.idle.clear",  32'(rep_clear),   32'd0);
    chk("fl.idle.sready", 32'(start_ready), 32'd1);
    @(negedge clk); next_valid = 1; next_ctx = 3'd0; next_pc = 32'hDEAD; #1;
    chk("fl.inactive.en", 32'(rep_en), 32'd0);

    // ---- locked request survives stall while another context starts
    @(negedge clk); next_valid = 0;
    start_valid = 1; start_ctx = 3'd1; start_pc = 32'h5000; #1;
    chk("lk.idle.fvalid", 32'(fetch_valid), 32'd0);
    @(negedge clk); start_ctx = 3'd3; start_pc = 32'h6000; #1;
    chk_fetch("lk.f0", 3'd1, 32'h5000);
    @(negedge clk); start_valid = 0; stall = 5'b00010; #1;
    chk_fetch("lk.f1", 3'd1, 32'h5000);
    @(negedge clk); #1;
    chk_fetch("lk.f2", 3'd1, 32'h5000);
    @(negedge clk); fetch_ready = 1; #1;
    chk_fetch("lk.f3", 3'd1, 32'h5000);
    @(negedge clk); stall = '0; #1;
    chk_fetch("lk.f4", 3'd3, 32'h6000);

    // ---- next and start in the same cycle
    @(negedge clk); next_valid = 1; next_ctx = 3'd1; next_pc = 32'h5004;
    start_valid = 1; start_ctx = 3'd0; start_pc = 32'h7000; #1;
    chk("ns.fvalid", 32'(fetch_valid), 32'd0);
    chk("ns.sready", 32'(start_ready), 32'd0);
    chk_wr("ns.next", 3'd1, 32'h5004);
    @(negedge clk); next_valid = 0; #1;
    chk("ns.sready2", 32'(start_ready), 32'd1);
    chk_wr("ns.start", 3'd0, 32'h7000);
    chk_fetch("ns.f", 3'd1, 32'h5004);

    // ---- halt of inflight ctx3, then its next-PC is dropped
    @(negedge clk); start_valid = 0; halt_valid = 1; halt_ctx = 3'd3; #1;
    chk_fetch("ht.f", 3'd0, 32'h7000);
    @(negedge clk); halt_valid = 0; next_valid = 1; next_ctx = 3'd3; next_pc = 32'h6004; #1;
    chk("ht.next.en", 32'(rep_en),      32'd0);
    chk("ht.fvalid",  32'(fetch_valid), 32'd0);

    // ---- out-of-range start and next
    @(negedge clk); next_valid = 0; start_valid = 1; start_ctx = 3'd7; start_pc = 32'hBAD0; #1;
    chk("oor.start.sready", 32'(start_ready), 32'd1);
    chk("oor.start.en",     32'(rep_en),      32'd0);
    @(negedge clk); start_valid = 0; next_valid = 1; next_ctx = 3'd6; next_pc = 32'hBAD1; #1;
    chk("oor.next.en", 32'(rep_en), 32'd0);

    // ---- halt and start on the same context: PC written, halt wins
    @(negedge clk); next_valid = 0; start_valid = 1; start_ctx = 3'd2; start_pc = 32'h8000;
    halt_valid = 1; halt_ctx = 3'd2; #1;
    chk_wr("hs.wr", 3'd2, 32'h8000);
    @(negedge clk); start_valid = 0; halt_valid = 0; #1;
    chk("hs.fvalid", 32'(fetch_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
